// File: rtl/fpga_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : fpga_cfg_loader
// Purpose  : Wishbone-controlled serial loader for an FPGA fabric
//            configuration chain. Software sets the bit count and clock
//            divider in CFG, feeds 32-bit words through DATA, and pulses
//            START. The block then pulses prog_reset and shifts the words
//            into the chain LSB-first on ccff_head, clocked by prog_clk.
//            Each bit is also sampled from ccff_tail into an RX register
//            that software can read back.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   wb_clk_i    in   1   sole clock, rising edge
//   wb_rst_n    in   1   asynchronous active-low reset
//   wbs_stb_i   in   1   Wishbone strobe
//   wbs_cyc_i   in   1   Wishbone cycle
//   wbs_we_i    in   1   Wishbone write enable
//   wbs_adr_i   in   4   byte address, [3:2] selects the register
//   wbs_dat_i   in   32  write data (always full-word)
//   wbs_ack_o   out  1   single-cycle acknowledge
//   wbs_dat_o   out  32  read data, valid while wbs_ack_o is high
//   prog_clk    out  1   configuration chain clock
//   prog_reset  out  1   configuration chain reset, active-high
//   ccff_head   out  1   serial data into the chain
//   ccff_tail   in   1   serial data out of the chain
//   done_irq    out  1   one-cycle pulse when a load finishes
// Registers (wbs_adr_i[3:2])
//   0 CTRL   W   bit0 START, bit1 ABORT (self-clearing, reads 0)
//   1 STATUS R   bit0 busy, bit1 buf_full, bit2 done (W1C),
//                bit3 overflow (W1C), [31:8] bits_remaining
//   2 DATA   RW  write: TX buffer, read: RX capture
//   3 CFG    RW  [CLKDIV_W-1:0] div, [31:8] nbits
// ============================================================================
module fpga_cfg_loader #(
  parameter int CLKDIV_W    = 8,
  parameter int PRST_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_clk,
  output logic        prog_reset,
  output logic        ccff_head,
  input  logic        ccff_tail,
  output logic        done_irq
);

  localparam int PRST_W = (PRST_CYCLES > 1) ? $clog2(PRST_CYCLES) : 1;
  localparam logic [PRST_W-1:0] c_PRST_LAST = PRST_W'(PRST_CYCLES - 1);

  localparam logic [1:0] c_REG_CTRL   = 2'd0;
  localparam logic [1:0] c_REG_STATUS = 2'd1;
  localparam logic [1:0] c_REG_DATA   = 2'd2;
  localparam logic [1:0] c_REG_CFG    = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRST = 3'd1,
    WAIT = 3'd2,
    LO   = 3'd3,
    HI   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Bus registers
  logic                r_ack;
  logic [31:0]         r_dat_o;
  logic [31:0]         w_rd_data;

  // Software-visible registers
  logic [CLKDIV_W-1:0] r_cfg_div;
  logic [23:0]         r_cfg_nbits;
  logic [31:0]         r_txbuf;
  logic                r_buf_full;
  logic [31:0]         r_rx;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic [23:0]         r_bits_rem;

  // Engine registers
  logic [31:0]         r_shift;
  logic [4:0]          r_bit_idx;
  logic [CLKDIV_W-1:0] r_div_cnt;
  logic [PRST_W-1:0]   r_prst_cnt;
  logic                r_prog_clk;
  logic                r_prog_reset;
  logic                r_ccff_head;
  logic                r_done_irq;

  // Decoded bus strobes
  logic                w_req;
  logic                w_wr;
  logic                w_start;
  logic                w_abort;
  logic                w_wr_status;
  logic                w_wr_data;
  logic                w_wr_cfg;

  // FSM strobes
  logic                w_run_start;
  logic                w_load;
  logic                w_bit_end;
  logic                w_sample;
  logic                w_div_done;
  logic [31:0]         w_shift_nxt;
  logic [7:0]          w_div8;
  logic                w_unused_ok;

  // --------------------------------------------------------------------------
  // Wishbone decode. The request is acknowledged one cycle after it is seen;
  // register side-effects are applied at the end of that ack cycle, so the
  // master must keep stb/cyc/we/adr/dat stable through the ack cycle.
  // --------------------------------------------------------------------------
  assign w_req       = wbs_stb_i & wbs_cyc_i;
  assign w_wr        = r_ack & w_req & wbs_we_i;
  assign w_start     = w_wr & (wbs_adr_i[3:2] == c_REG_CTRL) & wbs_dat_i[0];
  assign w_abort     = w_wr & (wbs_adr_i[3:2] == c_REG_CTRL) & wbs_dat_i[1];
  assign w_wr_status = w_wr & (wbs_adr_i[3:2] == c_REG_STATUS);
  assign w_wr_data   = w_wr & (wbs_adr_i[3:2] == c_REG_DATA);
  assign w_wr_cfg    = w_wr & (wbs_adr_i[3:2] == c_REG_CFG);

  // The byte-lane bits of the address carry no meaning here.
  assign w_unused_ok = ^wbs_adr_i[1:0];

  // CFG readback places div in the low byte of the word.
  generate
    if (CLKDIV_W >= 8) begin : g_div_trunc
      assign w_div8 = r_cfg_div[7:0];
    end else begin : g_div_pad
      assign w_div8 = {{(8 - CLKDIV_W){1'b0}}, r_cfg_div};
    end
  endgenerate

  always_comb begin
    w_rd_data = '0;
    case (wbs_adr_i[3:2])
      c_REG_STATUS: w_rd_data = {r_bits_rem, 4'b0000, r_ovf, r_done, r_buf_full, r_busy};
      c_REG_DATA:   w_rd_data = r_rx;
      c_REG_CFG:    w_rd_data = {r_cfg_nbits, w_div8};
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ack   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack <= w_req & ~r_ack;
      // Capture read data in the request cycle so it is stable for the ack.
      if (w_req && !r_ack && !wbs_we_i) begin
        r_dat_o <= w_rd_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and engine strobes
  // --------------------------------------------------------------------------
  assign w_div_done = (r_div_cnt == r_cfg_div);

  always_comb begin
    w_state_nxt = r_state;
    w_run_start = 1'b0;
    w_load      = 1'b0;
    w_bit_end   = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start && !w_abort) begin
          w_run_start = 1'b1;
          w_state_nxt = (r_cfg_nbits != 24'd0) ? PRST : DONE;
        end
      end
      PRST: begin
        if (r_prst_cnt == c_PRST_LAST) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_buf_full) begin
          w_load      = 1'b1;
          w_state_nxt = LO;
        end
      end
      LO: begin
        if (w_div_done) begin
          w_state_nxt = HI;
        end
      end
      HI: begin
        // The chain clocks on the prog_clk rising edge; capture its output
        // once per bit, in the first high cycle.
        w_sample = (r_div_cnt == '0);
        if (w_div_done) begin
          w_bit_end = 1'b1;
          if (r_bits_rem == 24'd1) begin
            w_state_nxt = DONE;
          end else if (r_bit_idx == 5'd31) begin
            w_state_nxt = WAIT;
          end else begin
            w_state_nxt = LO;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // ABORT overrides everything, including a START in the same write.
    if (w_abort) begin
      w_state_nxt = IDLE;
      w_run_start = 1'b0;
      w_load      = 1'b0;
      w_bit_end   = 1'b0;
    end
  end

  assign w_shift_nxt = w_load    ? r_txbuf :
                       w_bit_end ? {1'b0, r_shift[31:1]} :
                                   r_shift;

  // --------------------------------------------------------------------------
  // Engine datapath and chain outputs. The chain outputs are registered from
  // the next state so prog_clk/prog_reset come straight from flops.
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_div_cnt    <= '0;
      r_prst_cnt   <= '0;
      r_bits_rem   <= '0;
      r_rx         <= '0;
      r_prog_clk   <= 1'b0;
      r_prog_reset <= 1'b0;
      r_ccff_head  <= 1'b0;
      r_done_irq   <= 1'b0;
    end else begin
      r_prog_clk   <= (w_state_nxt == HI);
      r_prog_reset <= (w_state_nxt == PRST);
      r_ccff_head  <= ((w_state_nxt == LO) || (w_state_nxt == HI)) ? w_shift_nxt[0] : 1'b0;
      r_done_irq   <= (w_state_nxt == DONE);
      r_shift      <= w_shift_nxt;

      if ((r_state == PRST) && (w_state_nxt == PRST)) begin
        r_prst_cnt <= r_prst_cnt + PRST_W'(1);
      end else begin
        r_prst_cnt <= '0;
      end

      // Half-period counter restarts on every LO/HI phase change.
      if (r_state != w_state_nxt) begin
        r_div_cnt <= '0;
      end else if ((r_state == LO) || (r_state == HI)) begin
        r_div_cnt <= r_div_cnt + CLKDIV_W'(1);
      end

      if (w_load) begin
        r_bit_idx <= '0;
      end else if (w_bit_end) begin
        r_bit_idx <= r_bit_idx + 5'd1;
      end

      if (w_run_start) begin
        r_bits_rem <= r_cfg_nbits;
      end else if (w_bit_end) begin
        r_bits_rem <= r_bits_rem - 24'd1;
      end

      if (w_sample) begin
        r_rx <= {ccff_tail, r_rx[31:1]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Software-visible registers and flags
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_cfg_div   <= '0;
      r_cfg_nbits <= '0;
      r_txbuf     <= '0;
      r_buf_full  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      // CFG is frozen while a load runs; the engine uses it live.
      if (w_wr_cfg && !r_busy) begin
        r_cfg_div   <= wbs_dat_i[CLKDIV_W-1:0];
        r_cfg_nbits <= wbs_dat_i[31:8];
      end

      // A write landing in the cycle the engine takes the buffer refills it.
      if (w_abort) begin
        r_buf_full <= 1'b0;
      end else if (w_wr_data && (!r_buf_full || w_load)) begin
        r_txbuf    <= wbs_dat_i;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end

      if (w_wr_data && r_buf_full && !w_load) begin
        r_ovf <= 1'b1;
      end else if (w_wr_status && wbs_dat_i[3]) begin
        r_ovf <= 1'b0;
      end

      if (w_abort) begin
        r_busy <= 1'b0;
      end else if (w_state_nxt == DONE) begin
        r_busy <= 1'b0;
      end else if (w_run_start) begin
        r_busy <= 1'b1;
      end

      if (w_state_nxt == DONE) begin
        r_done <= 1'b1;
      end else if (w_run_start || (w_wr_status && wbs_dat_i[2])) begin
        r_done <= 1'b0;
      end
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_dat_o;
  assign prog_clk   = r_prog_clk;
  assign prog_reset = r_prog_reset;
  assign ccff_head  = r_ccff_head;
  assign done_irq   = r_done_irq;

endmodule
`default_nettype wire

// File: doc/fpga_cfg_loader.md
FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 Parameter CLKDIV_W, default 8: width of the prog_clk half-period divider field.
REQ-002 Parameter PRST_CYCLES, default 16: prog_reset assertion length, in wb_clk_i cycles.
REQ-003 wb_clk_i  input  1  sole clock; all state SHALL be on its rising edge.
REQ-004 wb_rst_n  input  1  asynchronous, active-low reset.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone strobe, cycle and write-enable.
REQ-006 wbs_adr_i  input  4  byte address; [3:2] selects the register; [1:0] ignored.
REQ-007 wbs_dat_i  input  32  write data; wbs_sel_i is not connected and all writes are full-word.
REQ-008 wbs_ack_o  output  1  transfer acknowledge.
REQ-009 wbs_dat_o  output  32  read data.
REQ-010 prog_clk  output  1  fabric configuration clock.
REQ-011 prog_reset  output  1  fabric configuration reset, active-high.
REQ-012 ccff_head  output  1  configuration chain serial input.
REQ-013 ccff_tail  input  1  configuration chain serial output.
REQ-014 done_irq  output  1  one-cycle pulse when a load completes.

Function
REQ-015 Registers SHALL be addressed by wbs_adr_i[3:2]:
- 0 CTRL (W): bit0 START, bit1 ABORT; both self-clearing; reads return 0.
- 1 STATUS (R): bit0 busy, bit1 buf_full, bit2 done, bit3 overflow, [31:8] bits_remaining; a write of 1 to bit2 or bit3 clears that bit.
- 2 DATA: a write loads the 32-bit TX buffer; a read returns the RX capture register.
- 3 CFG (RW): [CLKDIV_W-1:0] div, [31:8] nbits.
REQ-016 Acknowledge: wbs_ack_o SHALL pulse for exactly one cycle, one cycle after stb&cyc is seen with ack low; no wait states; the register side-effect SHALL occur in the ack cycle.
REQ-017 FSM states SHALL be IDLE, PRST, WAIT, LO, HI, DONE.
REQ-018 IDLE: START with nbits!=0 -> PRST; busy=1, bits_remaining=nbits, done cleared. START with nbits==0 -> DONE directly.
REQ-019 PRST: prog_reset=1 for PRST_CYCLES cycles, then -> WAIT.
REQ-020 WAIT: if buf_full, move TX buffer to the shift register, clear buf_full, reset the per-word bit index to 0, and go to LO; otherwise stay.
REQ-021 LO: prog_clk=0; ccff_head=shift[0]; hold div+1 cycles, then -> HI.
REQ-022 HI: prog_clk=1 for div+1 cycles.
- In the first HI cycle, sample ccff_tail into the RX register: shift right, new bit at [31].
- At the end of HI, decrement bits_remaining and shift TX right.
- Exit: bits_remaining reaches 0 -> DONE; else the 32nd bit of the word -> WAIT; else -> LO.
REQ-023 DONE: done=1, done_irq pulses for one cycle, busy=0, -> IDLE.
REQ-024 A DATA write while buf_full=1 SHALL be dropped, buffer unchanged, and overflow set (sticky).
REQ-025 A DATA write in the same cycle that WAIT consumes the buffer SHALL be accepted and leave buf_full=1.
REQ-026 ABORT in any state SHALL force IDLE, prog_clk=0, prog_reset=0, busy=0, clear buf_full, and not set done; ABORT wins over a simultaneous START.
REQ-027 START while busy SHALL be ignored.
REQ-028 CFG writes while busy SHALL be ignored; CFG is sampled at START only.
REQ-029 The last word SHALL be partial when nbits is not a multiple of 32; unused upper TX bits are never driven out.
REQ-030 div=0 SHALL give prog_clk period = 2 wb_clk_i cycles.
REQ-031 Outside PRST, prog_reset SHALL be 0 in all states.

Reset
REQ-032 On wb_rst_n low, asynchronously:
- state=IDLE, prog_clk=0, prog_reset=0, ccff_head=0.
- wbs_ack_o=0, wbs_dat_o=0, done_irq=0.
- All registers and flags = 0, including CFG.
REQ-033 Reset asserted mid-load SHALL abandon the load with no further prog_clk edges; after release the block SHALL be in IDLE.

Verification
REQ-034 CFG div=1, nbits=8; DATA=0x000000A5; START -> prog_reset high 16 cycles; then 8 prog_clk pulses, 4 cycles per period; ccff_head sequence 1,0,1,0,0,1,0,1; done_irq once; STATUS=0x4.
REQ-035 Loopback (ccff_tail tied to ccff_head), nbits=32, DATA=0xDEADBEEF -> DATA read returns 0xDEADBEEF.
REQ-036 nbits=40, two DATA writes with the second issued while in WAIT -> 40 prog_clk pulses total; prog_clk idles low while buf_full=0.
REQ-037 Two DATA writes while buf_full=1 -> STATUS.overflow=1 and the first word is the one shifted.
REQ-038 ABORT after 5 bits -> prog_clk low next cycle; busy=0, done=0; a new START reruns PRST.
REQ-039 wb_rst_n pulsed low during HI -> prog_clk=0 immediately; all STATUS and CFG fields read 0.
